// File: rtl/multi_bank_switch.sv
// Frame-buffer bank arbiter between the camera writer and the VGA reader, NUM_BANKS >= 3.
// Drop/repeat statistics counters are built only when MULTI_BANK_SWITCH_STATS_EN is defined.
module multi_bank_switch #(
    parameter int NUM_BANKS   = 3,
    parameter int BANK_W      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_133,
    input  logic              vga_rise,
    input  logic              cam_rise,
    input  logic              freeze,
    output logic [BANK_W-1:0] vga_bank,
    output logic [BANK_W-1:0] cam_bank,
    output logic [BANK_W-1:0] ready_bank,
    output logic              ready_valid,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  repeat_cnt
);

    logic [SYNC_STAGES-1:0] vga_sync_q;
    logic [SYNC_STAGES-1:0] cam_sync_q;
    logic                   vga_pulse;
    logic                   cam_pulse;

    logic [BANK_W-1:0] vga_q, vga_d;
    logic [BANK_W-1:0] cam_q, cam_d;
    logic [BANK_W-1:0] rdy_q, rdy_d;
    logic              valid_q, valid_d;

    // Lowest bank index that is neither a nor b; pass a == b to exclude one bank.
    function automatic logic [BANK_W-1:0] lowest_free(input logic [BANK_W-1:0] a,
                                                      input logic [BANK_W-1:0] b);
        logic [BANK_W-1:0] r;
        logic              found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (!found && BANK_W'(i) != a && BANK_W'(i) != b) begin
                r     = BANK_W'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Bit 0 is the newest sample; a rising level yields one pulse in the last two stages.
    always_ff @(posedge clk) begin
        if (!rst_133) begin
            vga_sync_q <= '0;
            cam_sync_q <= '0;
        end else begin
            vga_sync_q <= {vga_sync_q[SYNC_STAGES-2:0], vga_rise};
            cam_sync_q <= {cam_sync_q[SYNC_STAGES-2:0], cam_rise};
        end
    end

    assign vga_pulse = vga_sync_q[SYNC_STAGES-2] & ~vga_sync_q[SYNC_STAGES-1];
    assign cam_pulse = cam_sync_q[SYNC_STAGES-2] & ~cam_sync_q[SYNC_STAGES-1];

    always_comb begin
        vga_d   = vga_q;
        cam_d   = cam_q;
        rdy_d   = rdy_q;
        valid_d = valid_q;
        if (!freeze) begin
            if (vga_pulse && cam_pulse) begin
                // The frame just completed goes straight to display.
                vga_d   = cam_q;
                cam_d   = lowest_free(cam_q, cam_q);
                valid_d = 1'b0;
            end else if (vga_pulse) begin
                if (valid_q) begin
                    vga_d   = rdy_q;
                    valid_d = 1'b0;
                end
            end else if (cam_pulse) begin
                rdy_d   = cam_q;
                valid_d = 1'b1;
                cam_d   = lowest_free(vga_q, cam_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_133) begin
            vga_q   <= '0;
            cam_q   <= BANK_W'(1);
            rdy_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            vga_q   <= vga_d;
            cam_q   <= cam_d;
            rdy_q   <= rdy_d;
            valid_q <= valid_d;
        end
    end

    assign vga_bank    = vga_q;
    assign cam_bank    = cam_q;
    assign ready_bank  = rdy_q;
    assign ready_valid = valid_q;

`ifdef MULTI_BANK_SWITCH_STATS_EN
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] rep_q, rep_d;

    // Saturating counters: hold at all-ones instead of wrapping.
    always_comb begin
        drop_d = drop_q;
        rep_d  = rep_q;
        if (!freeze) begin
            if (cam_pulse && valid_q && drop_q != {CNT_W{1'b1}})
                drop_d = drop_q + CNT_W'(1);
            if (vga_pulse && !cam_pulse && !valid_q && rep_q != {CNT_W{1'b1}})
                rep_d = rep_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_133) begin
            drop_q <= '0;
            rep_q  <= '0;
        end else begin
            drop_q <= drop_d;
            rep_q  <= rep_d;
        end
    end

    assign drop_cnt   = drop_q;
    assign repeat_cnt = rep_q;
`else
    assign drop_cnt   = '0;
    assign repeat_cnt = '0;
`endif

endmodule
